pixel_packet_assembler: RTL and testbench



---
 rtl/pixel_pkt_pkg.sv | 16 +
 rtl/pkt_timeout_counter.sv | 36 +++
 rtl/pixel_packet_assembler.sv | 162 ++++++++++++++++
 tb/tb_pixel_packet_assembler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkt_pkg.sv
// Shared FSM state encodings and default constants for the pixel packet assembler.
// ST_CSUM is only reachable when PKT_CHECKSUM_EN is defined.
package pixel_pkt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HUNT    = 3'd0;
  localparam state_t ST_PAYLOAD = 3'd1;
  localparam state_t ST_OUT     = 3'd2;
  localparam state_t ST_CSUM    = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hAA;
  localparam int unsigned TIMEOUT_DEF   = 1000000;

endpackage

// File: rtl/pkt_timeout_counter.sv
// Idle-cycle counter: clears on clr_i, counts while en_i, expires on the LIMIT-th cycle.
// LIMIT=0 disables expiry.
module pkt_timeout_counter
  import pixel_pkt_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != W'(LIMIT))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires during the LIMIT-th consecutive idle cycle.
  assign expire_o = (LIMIT != 0) && en_i
                  && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pixel_packet_assembler.sv
// Sync-hunting byte-to-pixel packer with backpressure, idle timeout, camera bypass.
// Define PKT_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module pixel_packet_assembler
  import pixel_pkt_pkg::*;
#(
  parameter int          DATA_WIDTH      = 8,
  parameter int          NUM_CH          = 3,
  parameter int          TOTAL_PIXELS    = 42240,
  parameter int          PIXEL_CNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         empty,
  input  logic [DATA_WIDTH-1:0]        pop_data,
  output logic                         pop,
  input  logic                         cam_mode,
  output logic [NUM_CH*DATA_WIDTH-1:0] pix_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [PIXEL_CNT_WIDTH-1:0]   pixel_cnt,
  output logic                         frame_done,
  output logic                         frame_err
);

  localparam int PW = NUM_CH * DATA_WIDTH;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                     state_q, state_d;
  logic [PW-1:0]              pix_q, pix_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic [PIXEL_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       in_wait;
  logic                       to_exp;
  logic                       csum_bad;

`ifdef PKT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_q, xor_d;

  assign in_wait  = (state_q == ST_PAYLOAD)
                  | (state_q == ST_CSUM);
  assign csum_bad = (state_q == ST_CSUM) & pop
                  & (pop_data != xor_q);
`else
  assign in_wait  = (state_q == ST_PAYLOAD);
  assign csum_bad = 1'b0;
`endif

  assign pop = ~empty & ((state_q == ST_HUNT) | in_wait);

  pkt_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (pop | ~in_wait),
    .en_i     (in_wait & empty),
    .expire_o (to_exp)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
`ifdef PKT_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (pop && pop_data == SYNC_BYTE) begin
          state_d = cam_mode ? ST_DONE : ST_PAYLOAD;
          ch_d    = '0;
`ifdef PKT_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (pop) begin
          // First byte of a pixel lands in the MSB channel.
          for (int k = 0; k < NUM_CH; k++)
            if (ch_q == CW'(k))
              pix_d[(NUM_CH-1-k)*DATA_WIDTH +: DATA_WIDTH] = pop_data;
`ifdef PKT_CHECKSUM_EN
          xor_d = xor_q ^ pop_data;
`endif
          if (ch_q == CW'(NUM_CH - 1)) begin
            ch_d    = '0;
            state_d = ST_OUT;
          end else begin
            ch_d = ch_q + CW'(1);
          end
        end
      end
      ST_OUT: begin
        if (pix_ready) begin
          if (cnt_q < PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1)) begin
            cnt_d   = cnt_q + PIXEL_CNT_WIDTH'(1);
            state_d = ST_PAYLOAD;
          end else begin
`ifdef PKT_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef PKT_CHECKSUM_EN
      ST_CSUM: begin
        if (pop) begin
          if (csum_bad) begin
            state_d = ST_HUNT;
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
    if (to_exp) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
      ch_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HUNT;
      pix_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
`ifdef PKT_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
`ifdef PKT_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign pix_data   = pix_q;
  assign pix_valid  = (state_q == ST_OUT);
  assign pixel_cnt  = cnt_q;
  assign frame_done = (state_q == ST_DONE);
  assign frame_err  = to_exp | csum_bad;

endmodule

// File: tb/tb_pixel_packet_assembler.sv
// Directed bench for pixel_packet_assembler: NUM_CH=3, TOTAL_PIXELS=4, TIMEOUT_CYCLES=16.
// Checksum sequences run only when PKT_CHECKSUM_EN is defined.
module tb_pixel_packet_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty;
  logic [7:0]  pop_data;
  logic        pop;
  logic        cam_mode;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pixel_cnt;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_packet_assembler #(
    .DATA_WIDTH      (8),
    .NUM_CH          (3),
    .TOTAL_PIXELS    (4),
    .PIXEL_CNT_WIDTH (16),
    .SYNC_BYTE       (8'hAA),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .pop_data   (pop_data),
    .pop        (pop),
    .cam_mode   (cam_mode),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pixel_cnt  (pixel_cnt),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic        e;
    logic [7:0]  d;
    logic        r;
    logic        cam;
    logic        pop;
    logic        vld;
    logic        chkd;
    logic [23:0] pd;
    logic [15:0] cnt;
    logic        done;
    logic        err;
  } vec_t;

  function automatic vec_t mk(
    input logic e, input logic [7:0] d,
    input logic r, input logic cam,
    input logic p, input logic vld,
    input logic chkd, input logic [23:0] pd,
    input logic [15:0] cnt,
    input logic done, input logic err);
    vec_t v;
    v.e = e; v.d = d; v.r = r; v.cam = cam;
    v.pop = p; v.vld = vld; v.chkd = chkd;
    v.pd = pd; v.cnt = cnt;
    v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle.
  task automatic step(input vec_t v, input string nm);
    empty     = v.e;
    pop_data  = v.d;
    pix_ready = v.r;
    cam_mode  = v.cam;
    @(negedge clk);
    chk({nm, ".pop"},   32'(pop),        32'(v.pop));
    chk({nm, ".valid"}, 32'(pix_valid),  32'(v.vld));
    chk({nm, ".cnt"},   32'(pixel_cnt),  32'(v.cnt));
    chk({nm, ".done"},  32'(frame_done), 32'(v.done));
    chk({nm, ".err"},   32'(frame_err),  32'(v.err));
    if (v.chkd)
      chk({nm, ".data"}, 32'(pix_data), 32'(v.pd));
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int hold,
                           input logic bad,
                           input string nm);
    logic [7:0]  b0;
    logic [23:0] pd;
    step(mk(0, 8'hAA, 1, 0, 1, 0, 0, 0, 0, 0, 0),
         {nm, ".sync"});
    for (int p = 0; p < 4; p++) begin
      b0 = 8'(3 * p + 1);
      pd = {b0, b0 + 8'd1, b0 + 8'd2};
      for (int c = 0; c < 3; c++)
        step(mk(0, b0 + 8'(c), 1, 0, 1, 0, 0, 0,
                16'(p), 0, 0),
             $sformatf("%s.p%0d.b%0d", nm, p, c));
      if (p == hold)
        for (int k = 0; k < 20; k++)
          step(mk(0, b0 + 8'd3, 0, 0, 0, 1, 1, pd,
                  16'(p), 0, 0),
               $sformatf("%s.p%0d.hold%0d", nm, p, k));
      step(mk(0, b0 + 8'd3, 1, 0, 0, 1, 1, pd,
              16'(p), 0, 0),
           $sformatf("%s.p%0d.out", nm, p));
    end
`ifdef PKT_CHECKSUM_EN
    if (bad) begin
      step(mk(0, 8'h0C ^ 8'hFF, 1, 0, 1, 0, 0, 0, 3, 0, 1),
           {nm, ".csum_bad"});
      step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
           {nm, ".no_done"});
      return;
    end
    step(mk(0, 8'h0C, 1, 0, 1, 0, 0, 0, 3, 0, 0),
         {nm, ".csum"});
`endif
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0),
         {nm, ".done"});
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
         {nm, ".idle"});
  endtask

  initial begin
    vec_t        tbl[$];
    logic [7:0]  b0;
    logic [23:0] pd;

    // Reset state, garbage, then one full frame.
    tbl.push_back(mk(1, 0,     1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h55, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h13, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hAA, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int p = 0; p < 4; p++) begin
      b0 = 8'(3 * p + 1);
      pd = {b0, b0 + 8'd1, b0 + 8'd2};
      for (int c = 0; c < 3; c++)
        tbl.push_back(mk(0, b0 + 8'(c), 1, 0, 1, 0, 0, 0,
                         16'(p), 0, 0));
      tbl.push_back(mk(0, b0 + 8'd3, 1, 0, 0, 1, 1, pd,
                       16'(p), 0, 0));
    end
`ifdef PKT_CHECKSUM_EN
    tbl.push_back(mk(0, 8'h0C, 1, 0, 1, 0, 0, 0, 3, 0, 0));
`endif
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    reset     = 1'b1;
    empty     = 1'b1;
    pop_data  = '0;
    pix_ready = 1'b0;
    cam_mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i])
      step(tbl[i], $sformatf("vec%0d", i));

    // Camera bypass: sync byte alone ends the frame.
    step(mk(0, 8'hAA, 1, 1, 1, 0, 0, 0, 0, 0, 0), "cam.sync");
    step(mk(1, 0,     1, 0, 0, 0, 0, 0, 0, 1, 0), "cam.done");
    step(mk(1, 0,     1, 0, 0, 0, 0, 0, 0, 0, 0), "cam.idle");

    run_frame(1, 1'b0, "bp");

    // Inter-byte timeout after five payload bytes.
    step(mk(0, 8'hAA, 1, 0, 1, 0, 0, 0, 0, 0, 0), "to.sync");
    for (int c = 0; c < 3; c++)
      step(mk(0, 8'(c + 1), 1, 0, 1, 0, 0, 0, 0, 0, 0),
           $sformatf("to.b%0d", c));
    step(mk(0, 8'h04, 1, 0, 0, 1, 1, 24'h010203, 0, 0, 0),
         "to.out");
    step(mk(0, 8'h04, 1, 0, 1, 0, 0, 0, 1, 0, 0), "to.b3");
    step(mk(0, 8'h05, 1, 0, 1, 0, 0, 0, 1, 0, 0), "to.b4");
    for (int k = 1; k < 16; k++)
      step(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0),
           $sformatf("to.idle%0d", k));
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1), "to.expire");
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "to.hunt");
    run_frame(-1, 1'b0, "after_to");

    // Reset in the middle of pixel 1.
    step(mk(0, 8'hAA, 1, 0, 1, 0, 0, 0, 0, 0, 0), "rst.sync");
    for (int c = 0; c < 3; c++)
      step(mk(0, 8'(c + 1), 1, 0, 1, 0, 0, 0, 0, 0, 0),
           $sformatf("rst.b%0d", c));
    step(mk(0, 8'h04, 1, 0, 0, 1, 1, 24'h010203, 0, 0, 0),
         "rst.out");
    step(mk(0, 8'h04, 1, 0, 1, 0, 0, 0, 1, 0, 0), "rst.b3");
    reset    = 1'b1;
    empty    = 1'b0;
    pop_data = 8'h05;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), "rst.after");
    run_frame(-1, 1'b0, "post_rst");

`ifdef PKT_CHECKSUM_EN
    run_frame(-1, 1'b1, "csum_wrong");
    run_frame(-1, 1'b0, "csum_ok");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
